// File: rtl/adler32_stream_ctrl.sv
// Adler-32 stream sequencer: forwards words downstream, paces the
// checksum engine, and appends the checksum as a trailer word.
module adler32_stream_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_val_i,
  output logic        s_rdy_o,
  input  logic [31:0] s_dat_i,
  input  logic [1:0]  s_num_i,
  input  logic        s_lst_i,
  output logic        m_val_o,
  input  logic        m_rdy_i,
  output logic [31:0] m_dat_o,
  output logic [1:0]  m_num_o,
  output logic        m_lst_o,
  output logic        eng_start_o,
  output logic        eng_val_o,
  output logic [31:0] eng_dat_o,
  output logic [1:0]  eng_num_o,
  output logic        eng_lst_o,
  input  logic        eng_done_i,
  input  logic [31:0] eng_dat_i,
  output logic [15:0] frm_cnt_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    WAIT_DONE,
    TRAIL
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  gap_cnt;
  logic [31:0] chk;
  logic        out_free;
  logic        feed_rdy;
  logic        hs;
  logic        ld_trl;

  assign out_free = !m_val_o | m_rdy_i;
  assign feed_rdy = (gap_cnt == 2'd0) & out_free;

  always_comb begin
    state_nx    = state;
    s_rdy_o     = 1'b0;
    eng_start_o = 1'b0;
    ld_trl      = 1'b0;
    case (state)
      IDLE: begin
        if (s_val_i) state_nx = START;
      end
      START: begin
        eng_start_o = 1'b1;
        state_nx    = FEED;
      end
      FEED: begin
        s_rdy_o = feed_rdy;
        if (s_val_i && feed_rdy && s_lst_i)
          state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (eng_done_i) state_nx = TRAIL;
      end
      TRAIL: begin
        if (out_free) begin
          ld_trl   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hs        = s_val_i & s_rdy_o;
  assign eng_val_o = hs;
  assign eng_dat_o = s_dat_i;
  assign eng_num_o = s_num_i;
  assign eng_lst_o = s_lst_i;
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      gap_cnt <= 2'd0;
      chk     <= 32'd0;
    end else begin
      state <= state_nx;
      // gap keeps engine inputs at least 4 cycles apart
      if (hs)
        gap_cnt <= 2'd3;
      else if (gap_cnt != 2'd0)
        gap_cnt <= gap_cnt - 2'd1;
      if (state == WAIT_DONE && eng_done_i)
        chk <= eng_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_val_o   <= 1'b0;
      m_dat_o   <= 32'd0;
      m_num_o   <= 2'd0;
      m_lst_o   <= 1'b0;
      frm_cnt_o <= 16'd0;
    end else begin
      if (hs) begin
        m_val_o <= 1'b1;
        m_dat_o <= s_dat_i;
        m_num_o <= s_num_i;
        m_lst_o <= 1'b0;
      end else if (ld_trl) begin
        m_val_o <= 1'b1;
        m_dat_o <= chk;
        m_num_o <= 2'd3;
        m_lst_o <= 1'b1;
      end else if (m_rdy_i) begin
        m_val_o <= 1'b0;
      end
      if (ld_trl)
        frm_cnt_o <= frm_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_adler32_stream_ctrl.sv
// Directed bench for adler32_stream_ctrl with a behavioural
// Adler-32 engine and a downstream sink with optional stalls.
module tb_adler32_stream_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_val_i = 1'b0;
  logic        s_rdy_o;
  logic [31:0] s_dat_i = 32'd0;
  logic [1:0]  s_num_i = 2'd0;
  logic        s_lst_i = 1'b0;
  logic        m_val_o;
  logic        m_rdy_i = 1'b1;
  logic [31:0] m_dat_o;
  logic [1:0]  m_num_o;
  logic        m_lst_o;
  logic        eng_start_o;
  logic        eng_val_o;
  logic [31:0] eng_dat_o;
  logic [1:0]  eng_num_o;
  logic        eng_lst_o;
  logic        eng_done_i;
  logic [31:0] eng_dat_i;
  logic [15:0] frm_cnt_o;
  logic        busy_o;

  adler32_stream_ctrl dut (
    .clk(clk), .rstn(rstn),
    .s_val_i(s_val_i), .s_rdy_o(s_rdy_o),
    .s_dat_i(s_dat_i), .s_num_i(s_num_i), .s_lst_i(s_lst_i),
    .m_val_o(m_val_o), .m_rdy_i(m_rdy_i),
    .m_dat_o(m_dat_o), .m_num_o(m_num_o), .m_lst_o(m_lst_o),
    .eng_start_o(eng_start_o), .eng_val_o(eng_val_o),
    .eng_dat_o(eng_dat_o), .eng_num_o(eng_num_o),
    .eng_lst_o(eng_lst_o), .eng_done_i(eng_done_i),
    .eng_dat_i(eng_dat_i), .frm_cnt_o(frm_cnt_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [34:0] m_q[$];
  int m_c[$];
  int s_c[$];
  int st_c[$];
  logic rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference engine: done 4 cycles after the last word
  logic [15:0] ea = 16'd1;
  logic [15:0] eb = 16'd0;
  int dcnt = 0;
  assign eng_done_i = (dcnt == 1);
  assign eng_dat_i = {eb, ea};

  always @(posedge clk) begin : engine
    logic [31:0] a, b;
    if (dcnt != 0) dcnt <= dcnt - 1;
    if (eng_start_o) begin
      ea <= 16'd1;
      eb <= 16'd0;
    end else if (eng_val_o) begin
      a = 32'(ea);
      b = 32'(eb);
      for (int i = 0; i <= int'(eng_num_o); i++) begin
        a = (a + 32'(eng_dat_o[31-8*i -: 8])) % 65521;
        b = (b + a) % 65521;
      end
      ea <= a[15:0];
      eb <= b[15:0];
      if (eng_lst_o) dcnt <= 4;
    end
  end

  logic stall = 1'b0;
  logic [34:0] held = 35'd0;

  always @(posedge clk) begin
    if (stall)
      chk("m_stable", 64'({m_lst_o, m_num_o, m_dat_o}), 64'(held));
    stall = m_val_o & !m_rdy_i;
    held = {m_lst_o, m_num_o, m_dat_o};
    if (s_val_i & s_rdy_o) s_c.push_back(cyc);
    if (m_val_o & m_rdy_i) begin
      m_q.push_back({m_lst_o, m_num_o, m_dat_o});
      m_c.push_back(cyc);
    end
    if (eng_start_o) st_c.push_back(cyc);
    cyc++;
  end

  always @(posedge clk) begin
    #2;
    if (rdy_rand)
      m_rdy_i = m_lst_o ? 1'b0 : 1'($urandom_range(0, 1));
    else
      m_rdy_i = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m_q.delete();
    m_c.delete();
    s_c.delete();
    st_c.delete();
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] n,
                      input logic l);
    int n0;
    int k;
    n0 = s_c.size();
    k = 0;
    s_val_i = 1'b1;
    s_dat_i = d;
    s_num_i = n;
    s_lst_i = l;
    do begin
      step();
      k++;
    end while (s_c.size() == n0 && k < 200);
    if (s_c.size() == n0) chk("hs_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_frm(input logic [15:0] tgt);
    int k;
    k = 0;
    while (!(frm_cnt_o == tgt && !m_val_o) && k < 500) begin
      step();
      k++;
    end
    chk("frm_cnt", 64'(frm_cnt_o), 64'(tgt));
  endtask

  task automatic send_wiki();
    send(32'h57696B69, 2'd3, 1'b0);
    send(32'h70656469, 2'd3, 1'b0);
    send(32'h61000000, 2'd0, 1'b1);
  endtask

  logic [34:0] wexp [4];

  initial begin
    wexp[0] = {1'b0, 2'd3, 32'h57696B69};
    wexp[1] = {1'b0, 2'd3, 32'h70656469};
    wexp[2] = {1'b0, 2'd0, 32'h61000000};
    wexp[3] = {1'b1, 2'd3, 32'h11E60398};

    step();
    step();
    chk("rst_m", 64'({m_val_o, m_lst_o, m_num_o, m_dat_o}), 64'(0));
    chk("rst_ctl", 64'({eng_start_o, eng_val_o, s_rdy_o, busy_o}), 64'(0));
    chk("rst_frm", 64'(frm_cnt_o), 64'(0));
    rstn = 1'b1;
    step();

    clr();
    send(32'h61626300, 2'd2, 1'b1);
    s_val_i = 1'b0;
    wait_frm(16'd1);
    chk("abc_n", 64'(m_q.size()), 64'(2));
    chk("abc_w0", 64'(m_q[0]), 64'({1'b0, 2'd2, 32'h61626300}));
    chk("abc_trl", 64'(m_q[1]), 64'({1'b1, 2'd3, 32'h024D0127}));
    chk("abc_start", 64'(s_c[0]), 64'(st_c[0] + 1));
    chk("abc_trl_t", 64'(m_c[1]), 64'(s_c[0] + 6));

    clr();
    send_wiki();
    s_val_i = 1'b0;
    wait_frm(16'd2);
    chk("wiki_gap1", 64'(s_c[1] - s_c[0]), 64'(4));
    chk("wiki_gap2", 64'(s_c[2] - s_c[1]), 64'(4));
    chk("wiki_n", 64'(m_q.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("wiki_w%0d", i), 64'(m_q[i]), 64'(wexp[i]));

    clr();
    rdy_rand = 1'b1;
    send_wiki();
    s_val_i = 1'b0;
    for (int k = 0; k < 300 && !(m_val_o && m_lst_o); k++) step();
    for (int k = 0; k < 10; k++) step();
    chk("bp_trl_held", 64'({m_val_o, m_lst_o, m_dat_o}),
        64'({2'b11, 32'h11E60398}));
    chk("bp_n_pre", 64'(m_q.size()), 64'(3));
    rdy_rand = 1'b0;
    wait_frm(16'd3);
    chk("bp_n", 64'(m_q.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_w%0d", i), 64'(m_q[i]), 64'(wexp[i]));

    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    clr();
    send(32'h61626300, 2'd2, 1'b1);
    send_wiki();
    s_val_i = 1'b0;
    wait_frm(16'd2);
    chk("b2b_starts", 64'(st_c.size()), 64'(2));
    chk("b2b_start2", 64'(st_c[1] >= s_c[0] + 7), 64'(1));
    chk("b2b_n", 64'(m_q.size()), 64'(6));
    chk("b2b_trl1", 64'(m_q[1]), 64'({1'b1, 2'd3, 32'h024D0127}));
    chk("b2b_trl2", 64'(m_q[5]), 64'({1'b1, 2'd3, 32'h11E60398}));

    clr();
    send(32'h57696B69, 2'd3, 1'b0);
    send(32'h70656469, 2'd3, 1'b0);
    s_val_i = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_m", 64'({m_val_o, m_lst_o, m_num_o, m_dat_o}), 64'(0));
    chk("mid_ctl", 64'({eng_start_o, eng_val_o, s_rdy_o, busy_o}), 64'(0));
    chk("mid_frm", 64'(frm_cnt_o), 64'(0));
    step();
    rstn = 1'b1;
    step();
    clr();
    send(32'h61626300, 2'd2, 1'b1);
    s_val_i = 1'b0;
    wait_frm(16'd1);
    chk("mid_n", 64'(m_q.size()), 64'(2));
    chk("mid_trl", 64'(m_q[1]), 64'({1'b1, 2'd3, 32'h024D0127}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adler32_stream_ctrl.md
# adler32_stream_ctrl

Sequencer for the `adler32` checksum engine on the zlib output path. It accepts a word stream and forwards it unchanged downstream. It feeds each word to the engine while respecting the engine's one-word-per-4-cycle acceptance rate. After the frame's last word it appends the 4-byte Adler-32 checksum as a separate trailer word. It sits between the deflate packer and the PNG IDAT chunk writer.

## Interface
Parameters:
- none; data width is fixed at 32 bits, byte count at 2 bits.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- s_val_i  in  1  upstream word valid
- s_rdy_o  out  1  upstream ready; handshake = s_val_i & s_rdy_o
- s_dat_i  in  32  upstream data, MSB-first bytes
- s_num_i  in  2  valid bytes minus 1 (0 → [31:24] only, 3 → all four)
- s_lst_i  in  1  last word of frame
- m_val_o  out  1  downstream word valid
- m_rdy_i  in  1  downstream ready
- m_dat_o  out  32  downstream data
- m_num_o  out  2  downstream valid bytes minus 1
- m_lst_o  out  1  last word of frame; set on the trailer only
- eng_start_o  out  1  engine start pulse
- eng_val_o  out  1  engine word valid
- eng_dat_o  out  32  engine data (= s_dat_i)
- eng_num_o  out  2  engine byte count (= s_num_i)
- eng_lst_o  out  1  engine last (= s_lst_i)
- eng_done_i  in  1  engine done pulse
- eng_dat_i  in  32  engine checksum {s2,s1}
- frm_cnt_o  out  16  completed frames; wraps 0xFFFF→0
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, START, FEED, WAIT_DONE, TRAIL.
- IDLE:
  - s_rdy_o=0.
  - s_val_i=1 → START.
- START:
  - eng_start_o=1 for exactly this cycle.
  - → FEED unconditionally.
- FEED:
  - s_rdy_o = (gap_cnt==0) & out_free, where out_free = !m_val_o | m_rdy_i.
  - On handshake: eng_val_o=1 in the same cycle (combinational), with eng_dat/num/lst driven from s_*.
  - On handshake: the output register loads {s_dat_i, s_num_i, lst=0}, and gap_cnt is set to 3.
  - On handshake with s_lst_i=1 → WAIT_DONE.
- gap_cnt:
  - 2-bit counter, decrements each cycle while nonzero.
  - Guarantees the engine sees accepted words at least 4 cycles apart.
- WAIT_DONE:
  - s_rdy_o=0.
  - On eng_done_i=1: the chk register captures eng_dat_i → TRAIL.
- TRAIL:
  - When out_free: the output register loads {chk, num=3, lst=1} → IDLE, and frm_cnt_o increments.
  - Otherwise hold in TRAIL.
- Output register (single entry):
  - m_val_o is set on load.
  - m_val_o clears on m_rdy_i when no new load occurs in the same cycle.
  - Load and drain in the same cycle are allowed and keep m_val_o=1.
- Checksum byte order: big-endian, {s2[15:8], s2[7:0], s1[15:8], s1[7:0]}.
- A frame must contain at least one word. Zero-length frames are not supported.
- eng_val_o is never asserted outside FEED. eng_start_o is never asserted outside START.
- Unknown or illegal state → IDLE.

## Timing
- Reset values:
  - m_val_o=0, m_dat_o=0, m_num_o=0, m_lst_o=0.
  - eng_start_o=0, eng_val_o=0.
  - s_rdy_o=0, busy_o=0, frm_cnt_o=0.
  - State=IDLE, gap_cnt=0, chk=0.
- Frame start: s_val_i first seen in IDLE at T0 → eng_start_o=1 at T1 → first word can be accepted at T2.
- Word acceptance:
  - Accepted at Ta → next acceptance no earlier than Ta+4.
  - Sustained throughput is 1 word / 4 cycles.
- Forwarding latency: a word accepted at Ta appears on m_* from Ta+1.
- Trailer:
  - Engine asserts done at Tl+4 for a last word accepted at Tl.
  - chk captured at Tl+4, TRAIL at Tl+5, trailer on m_* at Tl+6 if out_free at Tl+5.
  - frm_cnt_o updates at Tl+6.
  - IDLE at Tl+6; the next frame's eng_start_o is no earlier than Tl+7.
- Backpressure:
  - m_rdy_i=0 holds m_* stable and blocks acceptance.
  - gap_cnt keeps counting during stall.
- Reset mid-frame: all state clears immediately; the partial frame is dropped with no trailer and no frm_cnt_o update.
- eng_done_i outside WAIT_DONE is ignored.

## Test plan
- Single word "abc":
  - Stimulus: s_dat_i=0x61626300, s_num_i=2, s_lst_i=1.
  - Required: m_* carries 0x61626300 num=2 lst=0, then 0x024D0127 num=3 lst=1; frm_cnt_o=1.
- "Wikipedia":
  - Stimulus: words 0x57696B69/3, 0x70656469/3, 0x61000000/0 (last), with s_val_i held high.
  - Required: handshakes exactly 4 cycles apart; trailer 0x11E60398.
- Backpressure:
  - Stimulus: same frame as "Wikipedia", m_rdy_i toggled 0/1 randomly and held 0 for 10 cycles at the trailer.
  - Required: no word lost or duplicated; m_* stable while stalled; trailer 0x11E60398.
- Back-to-back frames:
  - Stimulus: "abc" then "Wikipedia".
  - Required: second eng_start_o no earlier than Tl+7; trailers 0x024D0127 then 0x11E60398; frm_cnt_o=2.
- Reset mid-frame:
  - Stimulus: rstn low after the 2nd word of "Wikipedia", then send "abc".
  - Required: all outputs at reset values during reset; trailer 0x024D0127 for "abc"; frm_cnt_o=1.
